// File: rtl/pu_msp430_mpy_pkg.sv
// Shared multiplier definitions: operating modes, register word offsets
// and the sequencer state encoding.
package pu_msp430_mpy_pkg;

    typedef enum logic [1:0] {
        MODE_MPY  = 2'd0,
        MODE_MPYS = 2'd1,
        MODE_MAC  = 2'd2,
        MODE_MACS = 2'd3
    } mpy_mode_t;

    localparam logic [2:0] OFS_OP1_MPY  = 3'd0;
    localparam logic [2:0] OFS_OP1_MPYS = 3'd1;
    localparam logic [2:0] OFS_OP1_MAC  = 3'd2;
    localparam logic [2:0] OFS_OP1_MACS = 3'd3;
    localparam logic [2:0] OFS_OP2      = 3'd4;
    localparam logic [2:0] OFS_RESLO    = 3'd5;
    localparam logic [2:0] OFS_RESHI    = 3'd6;
    localparam logic [2:0] OFS_SUMEXT   = 3'd7;

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_CLR_LO = 4'd1,
        S_CLR_HI = 4'd2,
        S_WR_OP1 = 4'd3,
        S_WR_OP2 = 4'd4,
        S_WAIT   = 4'd5,
        S_RD_LO  = 4'd6,
        S_RD_HI  = 4'd7,
        S_RD_EXT = 4'd8,
        S_RESP   = 4'd9
    } seq_state_t;

    function automatic logic [13:0] reg_word(input logic [13:0] base,
                                             input logic [2:0]  ofs);
        return base + {11'd0, ofs};
    endfunction

    function automatic logic [2:0] op1_ofs(input logic [1:0] mode);
        return {1'b0, mode};
    endfunction

endpackage

// File: rtl/pu_msp430_mpy_sequencer.sv
// Peripheral-bus master that drives one multiply / MAC step through the
// hardware multiplier and returns {RESHI,RESLO} plus SUMEXT.
module pu_msp430_mpy_sequencer
    import pu_msp430_mpy_pkg::*;
#(
    parameter logic [14:0] BASE_ADDR = 15'h0130,
    parameter int unsigned WAIT_CYC  = 1
) (
    input  logic        mclk,
    input  logic        puc_rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_mode,
    input  logic [15:0] cmd_op1,
    input  logic [15:0] cmd_op2,
    input  logic        cmd_first,
    input  logic        cmd_last,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_result,
    output logic [15:0] rsp_sumext,
    output logic [13:0] mst_addr,
    output logic [15:0] mst_din,
    output logic        mst_en,
    output logic [1:0]  mst_we,
    input  logic [15:0] mst_dout,
    output logic        busy
);

    localparam logic [13:0] BASE_WORD = BASE_ADDR[14:1];
    localparam int unsigned CNT_W = (WAIT_CYC > 1) ? $clog2(WAIT_CYC) : 1;
    localparam int unsigned CNT_LD = (WAIT_CYC > 0) ? WAIT_CYC - 1 : 0;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(CNT_LD);

    seq_state_t       state;
    mpy_mode_t        mode_q;
    logic [15:0]      op1_q;
    logic [15:0]      op2_q;
    logic             last_q;
    logic [CNT_W-1:0] wait_cnt;

    assign busy = (state != S_IDLE);

    always_ff @(posedge mclk or negedge puc_rst_n) begin
        if (!puc_rst_n) begin
            state      <= S_IDLE;
            mode_q     <= MODE_MPY;
            op1_q      <= '0;
            op2_q      <= '0;
            last_q     <= 1'b0;
            wait_cnt   <= '0;
            cmd_ready  <= 1'b1;
            rsp_valid  <= 1'b0;
            rsp_result <= '0;
            rsp_sumext <= '0;
            mst_addr   <= '0;
            mst_din    <= '0;
            mst_en     <= 1'b0;
            mst_we     <= 2'b00;
        end else begin
            mst_en <= 1'b0;
            mst_we <= 2'b00;
            unique case (state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        mode_q    <= mpy_mode_t'(cmd_mode);
                        op1_q     <= cmd_op1;
                        op2_q     <= cmd_op2;
                        last_q    <= cmd_last;
                        cmd_ready <= 1'b0;
                        mst_en    <= 1'b1;
                        mst_we    <= 2'b11;
                        // Only a MAC chain head clears the accumulator
                        if (cmd_mode[1] && cmd_first) begin
                            state    <= S_CLR_LO;
                            mst_addr <= reg_word(BASE_WORD, OFS_RESLO);
                            mst_din  <= '0;
                        end else begin
                            state    <= S_WR_OP1;
                            mst_addr <= reg_word(BASE_WORD, op1_ofs(cmd_mode));
                            mst_din  <= cmd_op1;
                        end
                    end
                end
                S_CLR_LO: begin
                    state    <= S_CLR_HI;
                    mst_en   <= 1'b1;
                    mst_we   <= 2'b11;
                    mst_addr <= reg_word(BASE_WORD, OFS_RESHI);
                    mst_din  <= '0;
                end
                S_CLR_HI: begin
                    state    <= S_WR_OP1;
                    mst_en   <= 1'b1;
                    mst_we   <= 2'b11;
                    mst_addr <= reg_word(BASE_WORD, op1_ofs(mode_q));
                    mst_din  <= op1_q;
                end
                S_WR_OP1: begin
                    state    <= S_WR_OP2;
                    mst_en   <= 1'b1;
                    mst_we   <= 2'b11;
                    mst_addr <= reg_word(BASE_WORD, OFS_OP2);
                    mst_din  <= op2_q;
                end
                S_WR_OP2: begin
                    state    <= S_WAIT;
                    wait_cnt <= CNT_LOAD;
                end
                S_WAIT: begin
                    if (wait_cnt == '0) begin
                        if (!mode_q[1] || last_q) begin
                            state    <= S_RD_LO;
                            mst_en   <= 1'b1;
                            mst_addr <= reg_word(BASE_WORD, OFS_RESLO);
                        end else begin
                            state     <= S_IDLE;
                            cmd_ready <= 1'b1;
                        end
                    end else begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end
                end
                S_RD_LO: begin
                    rsp_result[15:0] <= mst_dout;
                    state            <= S_RD_HI;
                    mst_en           <= 1'b1;
                    mst_addr         <= reg_word(BASE_WORD, OFS_RESHI);
                end
                S_RD_HI: begin
                    rsp_result[31:16] <= mst_dout;
                    state             <= S_RD_EXT;
                    mst_en            <= 1'b1;
                    mst_addr          <= reg_word(BASE_WORD, OFS_SUMEXT);
                end
                S_RD_EXT: begin
                    rsp_sumext <= mst_dout;
                    rsp_valid  <= 1'b1;
                    state      <= S_RESP;
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                        state     <= S_IDLE;
                    end
                end
                default: begin
                    state     <= S_IDLE;
                    cmd_ready <= 1'b1;
                    rsp_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
